// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. Owns the PC, issues in-order requests to
// instruction memory, tracks in-flight requests, and buffers responses in a
// small fetch queue whose head forms the IF-side payload of the IF/ID register.
// An EX redirect discards all queued instructions and marks every in-flight
// response as stale so it is dropped on return.
//
// Parameters:
//   RESET_PC   fetch address after reset
//   FQ_DEPTH   fetch queue entries and maximum in-flight requests (power of 2, >= 2)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   redirect_i/redirect_pc_i EX redirect and its target
//   imem_req_o/imem_addr_o   memory request valid and word-aligned address
//   imem_ready_i             memory accepts the request this cycle
//   imem_rvalid_i/rdata_i    in-order memory response
//   bp_query_pc_o            PC presented to the branch predictor
//   bp_pred_taken_i/target_i combinational prediction for bp_query_pc_o
//   id_ready_i               ID register accepts the head this cycle
//   pc_valid_o, pc_o, pc_p4_o, inst_o, bp_pred_taken_o, bp_pred_target_o
//                            fetch queue head payload (zero when empty)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] bp_query_pc_o,
    input  logic        bp_pred_taken_i,
    input  logic [31:0] bp_pred_target_i,
    input  logic        id_ready_i,
    output logic        pc_valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_p4_o,
    output logic [31:0] inst_o,
    output logic        bp_pred_taken_o,
    output logic [31:0] bp_pred_target_o
);
    localparam int PW = $clog2(FQ_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   pc_reg;

    // In-flight FIFO: request metadata waiting for its memory response.
    logic [31:0]   if_pc     [FQ_DEPTH];
    logic          if_taken  [FQ_DEPTH];
    logic [31:0]   if_target [FQ_DEPTH];
    logic [PW-1:0] if_wr_ptr;
    logic [PW-1:0] if_rd_ptr;
    logic [CW-1:0] inflight_cnt;

    // Fetch queue: completed fetches waiting for ID.
    logic [31:0]   fq_pc     [FQ_DEPTH];
    logic [31:0]   fq_inst   [FQ_DEPTH];
    logic          fq_taken  [FQ_DEPTH];
    logic [31:0]   fq_target [FQ_DEPTH];
    logic [PW-1:0] fq_wr_ptr;
    logic [PW-1:0] fq_rd_ptr;
    logic [CW-1:0] fq_cnt;

    // Responses still owed by memory for requests issued before a redirect.
    logic [CW-1:0] drop_cnt;

    logic [CW:0]   occupancy;
    logic          accept;
    logic          rsp;
    logic          rsp_keep;
    logic          fq_pop;
    logic [31:0]   next_pc;
    logic          unused_redirect_bits;

    // ---- request stage ----
    // Every in-flight request owns a future fetch queue slot, so limiting
    // in-flight plus queued entries to FQ_DEPTH means a kept response can
    // always be written without back-pressuring memory.
    assign occupancy     = {1'b0, inflight_cnt} + {1'b0, fq_cnt};
    assign imem_req_o    = !rst && !redirect_i && (occupancy < (CW+1)'(FQ_DEPTH));
    assign imem_addr_o   = pc_reg;
    assign bp_query_pc_o = pc_reg;
    assign accept        = imem_req_o && imem_ready_i;
    assign next_pc       = bp_pred_taken_i ? {bp_pred_target_i[31:2], 2'b00}
                                           : pc_reg + 32'd4;

    // ---- response stage ----
    // A response with nothing in flight is spurious and ignored entirely.
    assign rsp      = imem_rvalid_i && (inflight_cnt != '0);
    assign rsp_keep = rsp && !redirect_i && (drop_cnt == '0);

    // ---- output stage ----
    assign pc_valid_o       = (fq_cnt != '0);
    assign fq_pop           = pc_valid_o && id_ready_i && !redirect_i;
    assign pc_o             = pc_valid_o ? fq_pc[fq_rd_ptr] : 32'd0;
    assign pc_p4_o          = pc_valid_o ? fq_pc[fq_rd_ptr] + 32'd4 : 32'd0;
    assign inst_o           = pc_valid_o ? fq_inst[fq_rd_ptr] : 32'd0;
    assign bp_pred_taken_o  = pc_valid_o && fq_taken[fq_rd_ptr];
    assign bp_pred_target_o = pc_valid_o ? fq_target[fq_rd_ptr] : 32'd0;

    // Redirect targets are forced word-aligned; the low bits carry no meaning.
    assign unused_redirect_bits = ^redirect_pc_i[1:0];

    // Control state: PC, pointers and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_reg       <= RESET_PC;
            if_wr_ptr    <= '0;
            if_rd_ptr    <= '0;
            inflight_cnt <= '0;
            fq_wr_ptr    <= '0;
            fq_rd_ptr    <= '0;
            fq_cnt       <= '0;
            drop_cnt     <= '0;
        end else begin
            if (redirect_i) begin
                pc_reg <= {redirect_pc_i[31:2], 2'b00};
            end else if (accept) begin
                pc_reg <= next_pc;
            end

            if (accept) begin
                if_wr_ptr <= if_wr_ptr + PW'(1);
            end
            if (rsp) begin
                if_rd_ptr <= if_rd_ptr + PW'(1);
            end
            inflight_cnt <= inflight_cnt + CW'(accept) - CW'(rsp);

            // A response arriving in the redirect cycle is itself discarded,
            // so it is not counted among the ones still to be dropped.
            if (redirect_i) begin
                drop_cnt <= inflight_cnt - CW'(rsp);
            end else if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end

            if (redirect_i) begin
                fq_wr_ptr <= '0;
                fq_rd_ptr <= '0;
                fq_cnt    <= '0;
            end else begin
                if (rsp_keep) begin
                    fq_wr_ptr <= fq_wr_ptr + PW'(1);
                end
                if (fq_pop) begin
                    fq_rd_ptr <= fq_rd_ptr + PW'(1);
                end
                fq_cnt <= fq_cnt + CW'(rsp_keep) - CW'(fq_pop);
            end
        end
    end

    // Payload storage: written only under control of the pointers above.
    always_ff @(posedge clk) begin
        if (accept) begin
            if_pc[if_wr_ptr]     <= pc_reg;
            if_taken[if_wr_ptr]  <= bp_pred_taken_i;
            if_target[if_wr_ptr] <= bp_pred_target_i;
        end
        if (rsp_keep) begin
            fq_pc[fq_wr_ptr]     <= if_pc[if_rd_ptr];
            fq_inst[fq_wr_ptr]   <= imem_rdata_i;
            fq_taken[fq_wr_ptr]  <= if_taken[if_rd_ptr];
            fq_target[fq_wr_ptr] <= if_target[if_rd_ptr];
        end
    end

    // Memory must never return a response that was not requested.
    always_ff @(posedge clk) begin
        if (!rst && imem_rvalid_i) begin
            assert (inflight_cnt != '0);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] bp_query_pc_o;
    logic        bp_pred_taken_i;
    logic [31:0] bp_pred_target_i;
    logic        id_ready_i;
    logic        pc_valid_o;
    logic [31:0] pc_o;
    logic [31:0] pc_p4_o;
    logic [31:0] inst_o;
    logic        bp_pred_taken_o;
    logic [31:0] bp_pred_target_o;

    fetch_unit #(.RESET_PC(32'h0000_0000), .FQ_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_o       (imem_req_o),
        .imem_addr_o      (imem_addr_o),
        .imem_ready_i     (imem_ready_i),
        .imem_rvalid_i    (imem_rvalid_i),
        .imem_rdata_i     (imem_rdata_i),
        .bp_query_pc_o    (bp_query_pc_o),
        .bp_pred_taken_i  (bp_pred_taken_i),
        .bp_pred_target_i (bp_pred_target_i),
        .id_ready_i       (id_ready_i),
        .pc_valid_o       (pc_valid_o),
        .pc_o             (pc_o),
        .pc_p4_o          (pc_p4_o),
        .inst_o           (inst_o),
        .bp_pred_taken_o  (bp_pred_taken_o),
        .bp_pred_target_o (bp_pred_target_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Predictor: taken only at pred_pc; otherwise a recognisable dummy target.
    logic [31:0] pred_pc;
    logic [31:0] pred_tgt;
    assign bp_pred_taken_i  = (bp_query_pc_o == pred_pc);
    assign bp_pred_target_i = bp_pred_taken_i ? pred_tgt : (bp_query_pc_o ^ 32'h0000_1000);

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    typedef struct {
        logic [31:0] start;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] exp_next;
        logic [31:0] exp_p4;
        logic [31:0] exp_tgt;
    } vec_t;

    mreq_t mq[$];
    exp_t  expq[$];
    int    cyc;
    int    lat;
    int    acc_cnt;
    int    vec_cnt;
    int    err_cnt;
    logic  rst_ctl, ready_ctl, idr_ctl, redir_ctl;
    logic [31:0] rpc_ctl;
    logic [31:0] model_pc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vec_cnt++;
        if (act !== want) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, then observe and score.
    task automatic step();
        exp_t e;
        logic tk;
        logic [31:0] tg;
        @(negedge clk);
        cyc++;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = inst_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = 32'd0;
        end
        rst           = rst_ctl;
        imem_ready_i  = ready_ctl;
        id_ready_i    = idr_ctl;
        redirect_i    = redir_ctl;
        redirect_pc_i = rpc_ctl;
        #1;
        if (rst) begin
            expq.delete();
            model_pc = 32'h0000_0000;
        end else if (redirect_i) begin
            chk("req_in_redirect", {31'd0, imem_req_o}, 32'd0);
            expq.delete();
            model_pc = {redirect_pc_i[31:2], 2'b00};
        end else begin
            if (imem_req_o && imem_ready_i) begin
                chk("imem_addr", imem_addr_o, model_pc);
                chk("bp_query_pc", bp_query_pc_o, model_pc);
                tk = (model_pc == pred_pc);
                tg = tk ? pred_tgt : (model_pc ^ 32'h0000_1000);
                e.pc = model_pc;
                e.inst = inst_of(model_pc);
                e.taken = tk;
                e.target = tg;
                expq.push_back(e);
                mq.push_back('{addr: imem_addr_o, due: cyc + lat});
                acc_cnt++;
                model_pc = tk ? {tg[31:2], 2'b00} : model_pc + 32'd4;
            end
            if (pc_valid_o && id_ready_i) begin
                if (expq.size() == 0) begin
                    chk("unexpected_output_pc", pc_o, 32'hDEAD_BEEF);
                end else begin
                    e = expq.pop_front();
                    chk("out_pc", pc_o, e.pc);
                    chk("out_pc_p4", pc_p4_o, e.pc + 32'd4);
                    chk("out_inst", inst_o, e.inst);
                    chk("out_taken", {31'd0, bp_pred_taken_o}, {31'd0, e.taken});
                    chk("out_target", bp_pred_target_o, e.target);
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        ready_ctl = 1'b0;
        redir_ctl = 1'b0;
        idr_ctl   = 1'b1;
        for (int i = 0; i < 20 && mq.size() != 0; i++) step();
        chk("drain_before_reset", mq.size(), 32'd0);
        rst_ctl = 1'b1;
        step();
        step();
        rst_ctl   = 1'b0;
        ready_ctl = 1'b1;
    endtask

    vec_t vecs[5];

    initial begin
        int a0;
        int n;
        vec_cnt = 0; err_cnt = 0; cyc = 0; acc_cnt = 0; lat = 1;
        pred_pc = 32'h1; pred_tgt = 32'h0;
        rst_ctl = 1'b1; ready_ctl = 1'b0; idr_ctl = 1'b1; redir_ctl = 1'b0; rpc_ctl = 32'h0;
        rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; imem_ready_i = 1'b0;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; id_ready_i = 1'b1;
        model_pc = 32'h0;

        vecs[0] = '{32'h0000_0010, 1'b1, 32'h0000_0041, 32'h0000_0040, 32'h0000_0014, 32'h0000_0041};
        vecs[1] = '{32'hFFFF_FFFC, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_EFFC};
        vecs[2] = '{32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0104, 32'h0000_0104, 32'h0000_1100};
        vecs[3] = '{32'h0000_0020, 1'b1, 32'h0000_0203, 32'h0000_0200, 32'h0000_0024, 32'h0000_0203};
        vecs[4] = '{32'h0000_7FFC, 1'b0, 32'h0000_0000, 32'h0000_8000, 32'h0000_8000, 32'h0000_6FFC};

        // Reset state
        step();
        step();
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_addr", imem_addr_o, 32'h0000_0000);
        chk("rst_valid", {31'd0, pc_valid_o}, 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_pc_p4", pc_p4_o, 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_target", bp_pred_target_o, 32'd0);
        rst_ctl = 1'b0;
        ready_ctl = 1'b1;

        // Straight-line fetch with a 1-cycle memory
        a0 = acc_cnt;
        step();
        chk("first_cycle_valid", {31'd0, pc_valid_o}, 32'd0);
        step();
        chk("second_cycle_valid", {31'd0, pc_valid_o}, 32'd0);
        step();
        chk("latency_valid", {31'd0, pc_valid_o}, 32'd1);
        chk("latency_pc", pc_o, 32'h0000_0000);
        chk("latency_pc_p4", pc_p4_o, 32'h0000_0004);
        step();
        chk("back_to_back_accepts", acc_cnt - a0, 32'd4);
        run(4);

        // ID stall: credit closes at four outstanding, nothing lost on release
        idr_ctl = 1'b0;
        run(6);
        chk("stall_req_off", {31'd0, imem_req_o}, 32'd0);
        chk("stall_outstanding", expq.size(), 32'd4);
        chk("stall_valid", {31'd0, pc_valid_o}, 32'd1);
        idr_ctl = 1'b1;
        run(10);

        // Memory not ready: address holds, queue drains
        ready_ctl = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("notready_addr_stable", imem_addr_o, model_pc);
        end
        chk("notready_drained", {31'd0, pc_valid_o}, 32'd0);
        ready_ctl = 1'b1;
        run(6);

        // Table: prediction and wrap vectors, each entered via a redirect
        for (int v = 0; v < 5; v++) begin
            pred_pc  = vecs[v].taken ? vecs[v].start : 32'h1;
            pred_tgt = vecs[v].tgt;
            redir_ctl = 1'b1;
            rpc_ctl   = vecs[v].start;
            step();
            redir_ctl = 1'b0;
            step();
            step();
            chk("vec_next_addr", imem_addr_o, vecs[v].exp_next);
            step();
            chk("vec_head_valid", {31'd0, pc_valid_o}, 32'd1);
            chk("vec_head_pc", pc_o, vecs[v].start);
            chk("vec_head_pc_p4", pc_p4_o, vecs[v].exp_p4);
            chk("vec_head_taken", {31'd0, bp_pred_taken_o}, {31'd0, vecs[v].taken});
            chk("vec_head_target", bp_pred_target_o, vecs[v].exp_tgt);
            run(3);
        end
        pred_pc = 32'h1;

        // 3-cycle memory, two stale requests dropped after redirect
        do_reset();
        lat = 3;
        step();
        step();
        redir_ctl = 1'b1;
        rpc_ctl   = 32'h0000_0200;
        step();
        redir_ctl = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !pc_valid_o; i++) begin
            step();
            n++;
        end
        chk("slow_first_valid", {31'd0, pc_valid_o}, 32'd1);
        chk("slow_first_pc", pc_o, 32'h0000_0200);
        chk("slow_wait_cycles", n, 32'd5);
        run(8);

        // Redirect coinciding with the only outstanding response
        do_reset();
        lat = 1;
        step();
        redir_ctl = 1'b1;
        rpc_ctl   = 32'h0000_0300;
        step();
        redir_ctl = 1'b0;
        step();
        chk("coincident_stale_dropped", {31'd0, pc_valid_o}, 32'd0);
        step();
        step();
        chk("coincident_new_valid", {31'd0, pc_valid_o}, 32'd1);
        chk("coincident_new_pc", pc_o, 32'h0000_0300);
        run(6);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage producing the IF-side payload consumed by the IF/ID pipeline register: pc_valid, pc, pc+4, instruction, and branch-prediction taken/target.
- Owns the PC register, issues in-order requests to instruction memory, and tracks in-flight requests.
- Buffers responses in a small fetch queue so ID stalls never lose instructions.
- Handles redirects from EX by discarding stale in-flight and queued fetches.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset.
- FQ_DEPTH, 4, fetch queue entries and the maximum in-flight requests; power of 2, at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- redirect_i  in  1  EX redirect (mispredict, jump, trap)
- redirect_pc_i  in  32  redirect target
- imem_req_o  out  1  memory request valid
- imem_addr_o  out  32  request address; bits [1:0] are always 0
- imem_ready_i  in  1  memory accepts the request this cycle
- imem_rvalid_i  in  1  response valid; responses return in order with latency of at least 1
- imem_rdata_i  in  32  response instruction
- bp_query_pc_o  out  32  PC presented to the predictor; equals imem_addr_o
- bp_pred_taken_i  in  1  combinational prediction for bp_query_pc_o
- bp_pred_target_i  in  32  predicted target
- id_ready_i  in  1  ID register accepts this cycle (the inverse of ID stall)
- pc_valid_o  out  1  fetch queue head valid
- pc_o  out  32  head PC
- pc_p4_o  out  32  head PC+4
- inst_o  out  32  head instruction
- bp_pred_taken_o  out  1  head prediction
- bp_pred_target_o  out  32  head predicted target

Behaviour:
- Reset (rst high at a clk edge):
  - pc_reg = RESET_PC; fetch queue, in-flight tracker, and drop_cnt cleared.
  - pc_valid_o = 0; all data outputs read 0 while the queue is empty.
  - imem_req_o = 0 in the cycle rst is high.
  - Reset arriving mid-operation abandons any outstanding responses; the bench holds imem quiet during reset.
- Request credit:
  - imem_req_o = !rst && !redirect_i && (inflight_cnt + fq_cnt < FQ_DEPTH), using registered counts.
  - imem_addr_o = pc_reg.
- Request accept (imem_req_o && imem_ready_i):
  - Push {pc_reg, bp_pred_taken_i, bp_pred_target_i} into the in-flight FIFO.
  - pc_reg <= bp_pred_taken_i ? {target[31:2], 2'b00} : pc_reg + 4, modulo 2^32.
  - If imem_ready_i is low, pc_reg holds and imem_addr_o stays stable.
- Response (imem_rvalid_i):
  - Pop the in-flight FIFO head.
  - If drop_cnt > 0: discard the response and decrement drop_cnt.
  - Otherwise push {pc, pc+4, rdata, taken, target} into the fetch queue.
  - The credit rule guarantees the fetch queue is never full on a valid push.
  - imem_rvalid_i with an empty in-flight FIFO is ignored; simulation assertion.
- Output:
  - Outputs are driven combinationally from the fetch queue head; pc_valid_o = fq_cnt != 0.
  - A pop occurs when pc_valid_o && id_ready_i.
  - Push and pop in the same cycle leave fq_cnt unchanged.
- Latency:
  - With a 1-cycle memory, a request accepted at cycle t has its response at t+1 and appears on the outputs at t+2.
  - Steady-state throughput is 1 instruction per cycle with FQ_DEPTH >= 3.
- Redirect (highest priority):
  - pc_reg <= {redirect_pc_i[31:2], 2'b00}; fetch queue flushed; imem_req_o forced 0 that cycle.
  - drop_cnt <= inflight_cnt - (imem_rvalid_i ? 1 : 0).
  - A response arriving in the redirect cycle is discarded and still pops the in-flight FIFO.
  - Back-to-back redirects: each recomputes drop_cnt from the current inflight_cnt.
  - Requests resume the cycle after the redirect.
- Pointers and counters wrap modulo FQ_DEPTH; counters are log2(FQ_DEPTH)+1 bits wide.

Test Plan:
- Reset, then imem_ready=1 with a 1-cycle memory and id_ready=1 -> addresses 0,4,8,C on consecutive cycles; pc_valid_o rises 2 cycles after the first request; pc_p4_o = pc_o + 4.
- id_ready=0 for 6 cycles in steady state -> requests stop once inflight + queue = 4; no instruction is lost or duplicated; on release, PCs continue in order.
- Predicted taken at PC 0x10 with target 0x41 -> next imem_addr_o = 0x40; the ID payload for 0x10 carries taken=1, target=0x41.
- Memory with 3-cycle latency and 2 requests in flight; redirect to 0x200 -> both stale responses dropped; the first valid output has pc_o = 0x200.
- Redirect in the same cycle as imem_rvalid_i with 1 in flight -> drop_cnt = 0; that response is discarded; no request issues that cycle.
- imem_ready held 0 for 5 cycles -> imem_addr_o stays stable; pc_reg does not advance; pc_valid_o stays 0 once the queue drains.
- pc_reg at 0xFFFF_FFFC -> next address 0x0000_0000; pc_p4_o = 0x0000_0000.
